// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: fetch vs loader/debug, combinational grant, 1-cycle read data.
// Backpressure by withholding grants; fetch_stall_o flags a waiting fetch; the loader is forced in after STARVE_MAX denials.
module imem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              f_req_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    output logic              f_gnt_o,
    output logic              f_rvalid_o,
    output logic [DATA_W-1:0] f_rdata_o,
    output logic              fetch_stall_o,
    input  logic              flush_i,
    input  logic              l_req_i,
    input  logic              l_we_i,
    input  logic              l_lock_i,
    input  logic [ADDR_W-1:0] l_addr_i,
    input  logic [DATA_W-1:0] l_wdata_i,
    output logic              l_gnt_o,
    output logic              l_rvalid_o,
    output logic [DATA_W-1:0] l_rdata_o,
    output logic              im_en_o,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [DATA_W-1:0] im_wdata_o,
    input  logic [DATA_W-1:0] im_dout_i
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FETCH       = 2'd1,
        LOAD        = 2'd2,
        LOAD_LOCKED = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic               f_pend_q, l_pend_q;
    logic               starve_max;

    assign starve_max = (starve_cnt_q == CNT_W'(STARVE_MAX));

    always_comb begin
        f_gnt_o = 1'b0;
        l_gnt_o = 1'b0;
        state_d = IDLE;
        if (l_req_i && ((state_q == LOAD_LOCKED) || !f_req_i || starve_max)) begin
            l_gnt_o = 1'b1;
        end else if (f_req_i && !flush_i) begin
            f_gnt_o = 1'b1;
        end

        // A locked state whose loader dropped its request falls through to IDLE or FETCH here.
        if (l_gnt_o) begin
            state_d = l_lock_i ? LOAD_LOCKED : LOAD;
        end else if (f_gnt_o) begin
            state_d = FETCH;
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (l_req_i && !l_gnt_o) begin
            starve_cnt_d = starve_max ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        im_en_o    = f_gnt_o | l_gnt_o;
        im_we_o    = l_gnt_o & l_we_i;
        im_addr_o  = '0;
        im_wdata_o = '0;
        if (l_gnt_o) begin
            im_addr_o  = l_addr_i;
            im_wdata_o = l_wdata_i;
        end else if (f_gnt_o) begin
            im_addr_o  = f_addr_i;
        end
    end

    assign fetch_stall_o = f_req_i & ~f_gnt_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            f_pend_q     <= 1'b0;
            l_pend_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            f_pend_q     <= f_gnt_o;
            l_pend_q     <= l_gnt_o & ~l_we_i;
        end
    end

    // A flush in the response cycle kills the fetch data that is arriving.
    assign f_rvalid_o = f_pend_q & ~flush_i;
    assign l_rvalid_o = l_pend_q;
    assign f_rdata_o  = im_dout_i;
    assign l_rdata_o  = im_dout_i;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed table-driven bench for imem_arbiter plus hand sequences for starvation, locked burst and reset.
module tb_imem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        f_req_i, flush_i, l_req_i, l_we_i, l_lock_i;
    logic [31:0] f_addr_i, l_addr_i, l_wdata_i, im_dout_i;
    logic        f_gnt_o, f_rvalid_o, fetch_stall_o, l_gnt_o, l_rvalid_o;
    logic        im_en_o, im_we_o;
    logic [31:0] f_rdata_o, l_rdata_o, im_addr_o, im_wdata_o;

    int passed = 0;
    int total  = 0;

    imem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
        .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o), .fetch_stall_o(fetch_stall_o),
        .flush_i(flush_i),
        .l_req_i(l_req_i), .l_we_i(l_we_i), .l_lock_i(l_lock_i),
        .l_addr_i(l_addr_i), .l_wdata_i(l_wdata_i), .l_gnt_o(l_gnt_o),
        .l_rvalid_o(l_rvalid_o), .l_rdata_o(l_rdata_o),
        .im_en_o(im_en_o), .im_we_o(im_we_o), .im_addr_o(im_addr_o),
        .im_wdata_o(im_wdata_o), .im_dout_i(im_dout_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        flush;
        logic        l_req;
        logic        l_we;
        logic        l_lock;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        logic [31:0] dout;
        logic        e_fg;
        logic        e_lg;
        logic        e_frv;
        logic        e_lrv;
        logic        e_stall;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic fl,
                         input logic lr, input logic lw, input logic lk,
                         input logic [31:0] la, input logic [31:0] ld, input logic [31:0] dout);
        f_req_i = fr; f_addr_i = fa; flush_i = fl;
        l_req_i = lr; l_we_i = lw; l_lock_i = lk;
        l_addr_i = la; l_wdata_i = ld; im_dout_i = dout;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        //        f_req fa     fl lr lw lk la     ld     dout  | fg lg frv lrv st we addr   wdata  rdata
        vecs[0]  = '{0, 32'h0,   0, 0, 0, 0, 32'h0,  32'h0,  32'h0,  0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0};
        vecs[1]  = '{1, 32'h100, 0, 0, 0, 0, 32'h0,  32'h0,  32'h0,  1, 0, 0, 0, 0, 0, 32'h100, 32'h0,  32'h0};
        vecs[2]  = '{1, 32'h104, 0, 0, 0, 0, 32'h0,  32'h0,  32'hA,  1, 0, 1, 0, 0, 0, 32'h104, 32'h0,  32'hA};
        vecs[3]  = '{0, 32'h0,   0, 0, 0, 0, 32'h0,  32'h0,  32'hB,  0, 0, 1, 0, 0, 0, 32'h0,   32'h0,  32'hB};
        vecs[4]  = '{1, 32'h200, 0, 0, 0, 0, 32'h0,  32'h0,  32'h0,  1, 0, 0, 0, 0, 0, 32'h200, 32'h0,  32'h0};
        vecs[5]  = '{1, 32'h204, 1, 0, 0, 0, 32'h0,  32'h0,  32'hC,  0, 0, 0, 0, 1, 0, 32'h0,   32'h0,  32'hC};
        vecs[6]  = '{1, 32'h204, 0, 0, 0, 0, 32'h0,  32'h0,  32'h0,  1, 0, 0, 0, 0, 0, 32'h204, 32'h0,  32'h0};
        vecs[7]  = '{0, 32'h0,   0, 1, 0, 0, 32'h40, 32'h99, 32'hD,  0, 1, 1, 0, 0, 0, 32'h40,  32'h99, 32'hD};
        vecs[8]  = '{0, 32'h0,   1, 0, 0, 0, 32'h0,  32'h0,  32'hE,  0, 0, 0, 1, 0, 0, 32'h0,   32'h0,  32'hE};
        vecs[9]  = '{1, 32'h300, 1, 1, 1, 0, 32'h44, 32'h55, 32'h0,  0, 0, 0, 0, 1, 0, 32'h0,   32'h0,  32'h0};
        vecs[10] = '{0, 32'h0,   0, 1, 1, 0, 32'h44, 32'h55, 32'h0,  0, 1, 0, 0, 0, 1, 32'h44,  32'h55, 32'h0};
        vecs[11] = '{0, 32'h0,   0, 0, 0, 0, 32'h0,  32'h0,  32'hF,  0, 0, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0};

        // Reset: registered outputs low, grants still follow inputs.
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        drive(1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_f_rvalid", f_rvalid_o, 0);
        chk("rst_l_rvalid", l_rvalid_o, 0);
        chk("rst_f_gnt_comb", f_gnt_o, 1);
        chk("rst_im_addr_comb", im_addr_o, 32'h10);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post_rst_f_rvalid", f_rvalid_o, 0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].flush, vecs[i].l_req, vecs[i].l_we,
                  vecs[i].l_lock, vecs[i].l_addr, vecs[i].l_wdata, vecs[i].dout);
            #1;
            chk($sformatf("v%0d_f_gnt", i), f_gnt_o, vecs[i].e_fg);
            chk($sformatf("v%0d_l_gnt", i), l_gnt_o, vecs[i].e_lg);
            chk($sformatf("v%0d_f_rvalid", i), f_rvalid_o, vecs[i].e_frv);
            chk($sformatf("v%0d_l_rvalid", i), l_rvalid_o, vecs[i].e_lrv);
            chk($sformatf("v%0d_stall", i), fetch_stall_o, vecs[i].e_stall);
            chk($sformatf("v%0d_im_en", i), im_en_o, vecs[i].e_fg | vecs[i].e_lg);
            chk($sformatf("v%0d_im_we", i), im_we_o, vecs[i].e_we);
            chk($sformatf("v%0d_im_addr", i), im_addr_o, vecs[i].e_addr);
            chk($sformatf("v%0d_im_wdata", i), im_wdata_o, vecs[i].e_wdata);
            if (vecs[i].e_frv) chk($sformatf("v%0d_f_rdata", i), f_rdata_o, vecs[i].e_rdata);
            if (vecs[i].e_lrv) chk($sformatf("v%0d_l_rdata", i), l_rdata_o, vecs[i].e_rdata);
        end

        // Starvation: fetch wins four cycles, loader forced on the fifth, fetch resumes.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            drive(1, 32'h400, 0, 1, 0, 0, 32'h80, 0, 32'h5A);
            #1;
            chk($sformatf("starve%0d_f_gnt", c), f_gnt_o, (c == 4) ? 1'b0 : 1'b1);
            chk($sformatf("starve%0d_l_gnt", c), l_gnt_o, (c == 4) ? 1'b1 : 1'b0);
            chk($sformatf("starve%0d_stall", c), fetch_stall_o, (c == 4) ? 1'b1 : 1'b0);
            chk($sformatf("starve%0d_l_rvalid", c), l_rvalid_o, (c == 5) ? 1'b1 : 1'b0);
        end

        // Locked burst: first beat waits out starvation, then three back-to-back loader writes.
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            drive(1, 32'h500, 0, 1, 1, 1, 32'h0, 32'h11, 0);
            #1;
            chk($sformatf("burst_wait%0d_f_gnt", c), f_gnt_o, 1);
        end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk_i);
            drive(1, 32'h500, 0, 1, 1, (b < 2) ? 1'b1 : 1'b0, 32'(b * 4), 32'h11 + 32'(b), 0);
            #1;
            chk($sformatf("burst%0d_l_gnt", b), l_gnt_o, 1);
            chk($sformatf("burst%0d_f_gnt", b), f_gnt_o, 0);
            chk($sformatf("burst%0d_im_we", b), im_we_o, 1);
            chk($sformatf("burst%0d_im_addr", b), im_addr_o, 32'(b * 4));
            chk($sformatf("burst%0d_im_wdata", b), im_wdata_o, 32'h11 + 32'(b));
            chk($sformatf("burst%0d_l_rvalid", b), l_rvalid_o, 0);
        end
        @(negedge clk_i);
        drive(1, 32'h500, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("burst_end_f_gnt", f_gnt_o, 1);
        chk("burst_end_l_rvalid", l_rvalid_o, 0);

        // Reset mid-read: locked loader read is dropped and state returns to IDLE.
        @(negedge clk_i);
        drive(0, 0, 0, 1, 0, 1, 32'h80, 0, 0);
        #1;
        chk("rstrd_l_gnt", l_gnt_o, 1);
        rst_i = 1'b1;
        #1;
        chk("rstrd_l_gnt_in_rst", l_gnt_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(1, 32'h600, 0, 1, 0, 0, 32'h84, 0, 32'h77);
        #1;
        chk("rstrd_l_rvalid", l_rvalid_o, 0);
        chk("rstrd_f_gnt_idle", f_gnt_o, 1);
        chk("rstrd_l_gnt_idle", l_gnt_o, 0);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h78);
        #1;
        chk("rstrd_f_rvalid_after", f_rvalid_o, 1);
        chk("rstrd_f_rdata_after", f_rdata_o, 32'h78);
        chk("idle_im_en", im_en_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
